// File: rtl/ps2_ascii_pkg.sv
// Shared scancode constants, decode-state type and the set-2 to ASCII lookup
// used by the PS/2 keyboard encoder.
package ps2_ascii_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} dec_state_e;

    // Returns {valid, ascii}; valid = 0 for codes with no printable mapping.
    function automatic logic [8:0] sc2ascii(input logic [7:0] code, input logic shift,
                                            input logic caps);
        logic       letter;
        logic       digit;
        logic       other;
        logic [7:0] base;
        logic [7:0] alt;
        letter = 1'b0;
        digit  = 1'b0;
        other  = 1'b0;
        base   = 8'h00;
        alt    = 8'h00;
        case (code)
            8'h1C: begin letter = 1'b1; base = "a"; end
            8'h32: begin letter = 1'b1; base = "b"; end
            8'h21: begin letter = 1'b1; base = "c"; end
            8'h23: begin letter = 1'b1; base = "d"; end
            8'h24: begin letter = 1'b1; base = "e"; end
            8'h2B: begin letter = 1'b1; base = "f"; end
            8'h34: begin letter = 1'b1; base = "g"; end
            8'h33: begin letter = 1'b1; base = "h"; end
            8'h43: begin letter = 1'b1; base = "i"; end
            8'h3B: begin letter = 1'b1; base = "j"; end
            8'h42: begin letter = 1'b1; base = "k"; end
            8'h4B: begin letter = 1'b1; base = "l"; end
            8'h3A: begin letter = 1'b1; base = "m"; end
            8'h31: begin letter = 1'b1; base = "n"; end
            8'h44: begin letter = 1'b1; base = "o"; end
            8'h4D: begin letter = 1'b1; base = "p"; end
            8'h15: begin letter = 1'b1; base = "q"; end
            8'h2D: begin letter = 1'b1; base = "r"; end
            8'h1B: begin letter = 1'b1; base = "s"; end
            8'h2C: begin letter = 1'b1; base = "t"; end
            8'h3C: begin letter = 1'b1; base = "u"; end
            8'h2A: begin letter = 1'b1; base = "v"; end
            8'h1D: begin letter = 1'b1; base = "w"; end
            8'h22: begin letter = 1'b1; base = "x"; end
            8'h35: begin letter = 1'b1; base = "y"; end
            8'h1A: begin letter = 1'b1; base = "z"; end
            8'h16: begin digit = 1'b1; base = "1"; alt = "!"; end
            8'h1E: begin digit = 1'b1; base = "2"; alt = "@"; end
            8'h26: begin digit = 1'b1; base = "3"; alt = "#"; end
            8'h25: begin digit = 1'b1; base = "4"; alt = "$"; end
            8'h2E: begin digit = 1'b1; base = "5"; alt = "%"; end
            8'h36: begin digit = 1'b1; base = "6"; alt = "^"; end
            8'h3D: begin digit = 1'b1; base = "7"; alt = "&"; end
            8'h3E: begin digit = 1'b1; base = "8"; alt = "*"; end
            8'h46: begin digit = 1'b1; base = "9"; alt = "("; end
            8'h45: begin digit = 1'b1; base = "0"; alt = ")"; end
            8'h29: begin other = 1'b1; base = 8'h20; end
            8'h5A: begin other = 1'b1; base = 8'h0D; end
            8'h66: begin other = 1'b1; base = 8'h08; end
            default: ;
        endcase
        if (letter) return {1'b1, ((shift ^ caps) ? base - 8'h20 : base)};
        if (digit)  return {1'b1, (shift ? alt : base)};
        if (other)  return {1'b1, base};
        return 9'h000;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is always visible on rd_data
// (zero when empty). A write while full is accepted only alongside a read.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == AW'(0) + (AW+1)'(DEPTH));
    assign count   = count_q;
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/ps2_ascii_encoder.sv
// PS/2 set-2 scancode to ASCII translator with modifier tracking, feeding a
// character queue toward the serial transmitter's req/ack port.
module ps2_ascii_encoder
    import ps2_ascii_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    k_data,
    input  logic                          k_flag,
    output logic                          s_req,
    output logic [7:0]                    s_data,
    input  logic                          s_ack,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    logic       k_flag_d;
    logic       byte_vld_q;
    logic [7:0] byte_q;
    dec_state_e state_q, state_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d, caps_q, caps_d;
    logic       push_q, push_d;
    logic [7:0] char_q, char_d;
    logic       ovf_q;
    logic       full, empty, pop;
    logic [8:0] lut;

    // Byte capture stage: one strobe per k_flag rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_flag_d   <= 1'b0;
            byte_vld_q <= 1'b0;
            byte_q     <= 8'h00;
        end else begin
            k_flag_d   <= k_flag;
            byte_vld_q <= k_flag & ~k_flag_d;
            if (k_flag & ~k_flag_d) byte_q <= k_data;
        end
    end

    assign lut = sc2ascii(byte_q, lshift_q | rshift_q, caps_q);

    always_comb begin
        state_d  = state_q;
        lshift_d = lshift_q;
        rshift_d = rshift_q;
        caps_d   = caps_q;
        push_d   = 1'b0;
        char_d   = 8'h00;
        if (byte_vld_q) begin
            unique case (state_q)
                StIdle: begin
                    if (byte_q == SC_BREAK) state_d = StBrk;
                    else if (byte_q == SC_EXT) state_d = StExt;
                    else if (byte_q == SC_LSHIFT) lshift_d = 1'b1;
                    else if (byte_q == SC_RSHIFT) rshift_d = 1'b1;
                    else if (byte_q == SC_CAPS) caps_d = ~caps_q;
                    else begin
                        push_d = lut[8];
                        char_d = lut[7:0];
                    end
                end
                StBrk: begin
                    state_d = StIdle;
                    if (byte_q == SC_LSHIFT) lshift_d = 1'b0;
                    if (byte_q == SC_RSHIFT) rshift_d = 1'b0;
                end
                StExt: begin
                    if (byte_q == SC_BREAK) state_d = StExtBrk;
                    else begin
                        state_d = StIdle;
                        if (byte_q == SC_ENTER) begin
                            push_d = 1'b1;
                            char_d = 8'h0D;
                        end
                    end
                end
                StExtBrk: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
            caps_q   <= 1'b0;
            push_q   <= 1'b0;
            char_q   <= 8'h00;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lshift_q <= lshift_d;
            rshift_q <= rshift_d;
            caps_q   <= caps_d;
            push_q   <= push_d;
            char_q   <= char_d;
            if (push_q & full & ~pop) ovf_q <= 1'b1;
        end
    end

    assign s_req = ~empty;
    assign pop   = s_req & s_ack;
    assign ovf   = ovf_q;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_q),
        .wr_data (char_q),
        .rd_en   (s_ack),
        .rd_data (s_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_ps2_ascii_encoder.sv
// Directed bench for ps2_ascii_encoder: scancode sequences in, delivered
// characters collected at the req/ack port and compared to hand-worked values.
module tb_ps2_ascii_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] k_data;
    logic       k_flag;
    logic       s_req;
    logic [7:0] s_data;
    logic       s_ack;
    logic       ovf;
    logic [3:0] fifo_count;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] rxq [$];

    always #10 clk = ~clk;

    ps2_ascii_encoder #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .k_data     (k_data),
        .k_flag     (k_flag),
        .s_req      (s_req),
        .s_data     (s_data),
        .s_ack      (s_ack),
        .ovf        (ovf),
        .fifo_count (fifo_count)
    );

    // Transfers complete on the next rising edge; sample them mid-cycle.
    always @(negedge clk) begin
        if (s_req && s_ack && !rst) rxq.push_back(s_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        k_data = b;
        k_flag = 1'b1;
        tick(1);
        k_flag = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1; k_data = 8'h00; k_flag = 1'b0; s_ack = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_req", 32'(s_req), 32'h0);
        chk("rst_data", 32'(s_data), 32'h00);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_cnt", 32'(fifo_count), 32'h0);

        // Make then break of 'a'.
        send(8'h1C); send(8'hF0); send(8'h1C);
        tick(6);
        chk("a_n", 32'(rxq.size()), 32'd1);
        chk("a_ch", 32'(rxq[0]), 32'h61);
        chk("a_cnt", 32'(fifo_count), 32'h0);
        rxq.delete();

        // k_flag held high for several cycles is one byte.
        k_data = 8'h32; k_flag = 1'b1; tick(4); k_flag = 1'b0; tick(1);
        send(8'hF0); send(8'h32);
        tick(6);
        chk("held_n", 32'(rxq.size()), 32'd1);
        chk("held_ch", 32'(rxq[0]), 32'h62);
        rxq.delete();

        // Left shift around a key, released before the next one.
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h12); send(8'h1C);
        tick(6);
        chk("sh_n", 32'(rxq.size()), 32'd2);
        chk("sh_ch0", 32'(rxq[0]), 32'h41);
        chk("sh_ch1", 32'(rxq[1]), 32'h61);
        rxq.delete();

        // Caps on: digit unaffected, letter upper; shift+digit symbol;
        // shift+caps gives lowercase; right shift on another digit.
        send(8'h58); send(8'hF0); send(8'h58); send(8'h16); send(8'h1C);
        send(8'h12); send(8'h16); send(8'h1C);
        send(8'hF0); send(8'h12);
        send(8'h59); send(8'h1E); send(8'hF0); send(8'h59);
        send(8'h58); send(8'hF0); send(8'h58);
        tick(6);
        chk("caps_n", 32'(rxq.size()), 32'd5);
        chk("caps_ch0", 32'(rxq[0]), 32'h31);
        chk("caps_ch1", 32'(rxq[1]), 32'h41);
        chk("caps_ch2", 32'(rxq[2]), 32'h21);
        chk("caps_ch3", 32'(rxq[3]), 32'h61);
        chk("caps_ch4", 32'(rxq[4]), 32'h40);
        rxq.delete();

        // Extended codes, then space proves return to idle; backspace too.
        send(8'hE0); send(8'h5A);
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h29); send(8'h66); send(8'h0E);
        tick(6);
        chk("ext_n", 32'(rxq.size()), 32'd3);
        chk("ext_ch0", 32'(rxq[0]), 32'h0D);
        chk("ext_ch1", 32'(rxq[1]), 32'h20);
        chk("ext_ch2", 32'(rxq[2]), 32'h08);
        rxq.delete();

        // Overflow with the transmitter stalled; typematic repeats all queue.
        s_ack = 1'b0;
        for (int i = 0; i < 10; i++) send(8'h1C);
        tick(6);
        chk("ovf_cnt", 32'(fifo_count), 32'd8);
        chk("ovf_flag", 32'(ovf), 32'h1);
        chk("ovf_req", 32'(s_req), 32'h1);
        chk("ovf_head", 32'(s_data), 32'h61);
        s_ack = 1'b1;
        tick(12);
        chk("drain_n", 32'(rxq.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("drain_ch", 32'(rxq[i]), 32'h61);
        chk("drain_cnt", 32'(fifo_count), 32'h0);
        chk("ovf_sticky", 32'(ovf), 32'h1);
        rxq.delete();

        // Reset with three queued characters and caps/shift/prefix pending.
        s_ack = 1'b0;
        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'h58); send(8'h12); send(8'hE0);
        tick(4);
        chk("pre_rst_cnt", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_req", 32'(s_req), 32'h0);
        chk("mid_rst_cnt", 32'(fifo_count), 32'h0);
        chk("mid_rst_ovf", 32'(ovf), 32'h0);
        tick(1);
        // Latency: edge N samples the rise, character visible after N+2.
        k_data = 8'h1C; k_flag = 1'b1;
        tick(1);
        k_flag = 1'b0;
        tick(1);
        chk("lat_n1_req", 32'(s_req), 32'h0);
        tick(1);
        chk("lat_n2_req", 32'(s_req), 32'h1);
        chk("lat_n2_data", 32'(s_data), 32'h61);
        s_ack = 1'b1;
        tick(4);
        chk("post_n", 32'(rxq.size()), 32'd1);
        chk("post_ch", 32'(rxq[0]), 32'h61);
        chk("post_cnt", 32'(fifo_count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
